// File: rtl/aes_key_mem.sv
// -----------------------------------------------------------------------------
// aes_key_mem
// Key expansion and round key store for the AES encipher datapath.
// On init, expands a 128- or 256-bit cipher key into 11 or 15 round keys,
// one key per clock, using a shared external combinational S-box word lookup.
//
// Ports:
//   clk        in   1    clock, all state on rising edge
//   reset_n    in   1    asynchronous active-low reset
//   key        in   256  cipher key (AES-128 uses key[255:128])
//   keylen     in   1    0 = AES-128, 1 = AES-256, sampled with init
//   init       in   1    single-cycle start of key expansion
//   round      in   4    round key index requested by the cipher
//   round_key  out  128  key_mem[round], combinational read (round 15 -> 0)
//   ready      out  1    high when idle and all round keys are valid
//   sboxw      out  32   word sent to the shared S-box
//   new_sboxw  in   32   SubWord(sboxw), same cycle
// -----------------------------------------------------------------------------
module aes_key_mem #(
    parameter logic       AES_128_BIT_KEY = 1'h0,
    parameter logic       AES_256_BIT_KEY = 1'h1,
    parameter logic [3:0] AES128_ROUNDS   = 4'ha,
    parameter logic [3:0] AES256_ROUNDS   = 4'he
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [255:0] key,
    input  logic         keylen,
    input  logic         init,
    input  logic [3:0]   round,
    output logic [127:0] round_key,
    output logic         ready,
    output logic [31:0]  sboxw,
    input  logic [31:0]  new_sboxw
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GEN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t         state_q;
    logic [127:0]   key_mem_q [0:14];
    logic [127:0]   prev_key0_q;
    logic [127:0]   prev_key1_q;
    logic [3:0]     round_ctr_q;
    logic [7:0]     rcon_q;
    logic           keylen_q;
    logic           ready_q;

    logic [127:0]   new_key_d;
    logic [31:0]    sboxw_s;
    logic [31:0]    t_s;
    logic           rcon_adv_s;
    logic [3:0]     last_round_s;

    // Multiply by x in GF(2^8) with the AES polynomial.
    function automatic logic [7:0] rcon_next(input logic [7:0] rc);
        return {rc[6:0], 1'b0} ^ (8'h1b & {8{rc[7]}});
    endfunction

    // Rotate a word left by one byte.
    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    // Running XOR across the four words of a base key, seeded by t.
    function automatic logic [127:0] xor_chain(input logic [127:0] base, input logic [31:0] t);
        logic [31:0] w0, w1, w2, w3;
        w0 = base[127:96] ^ t;
        w1 = base[95:64]  ^ w0;
        w2 = base[63:32]  ^ w1;
        w3 = base[31:0]   ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    assign last_round_s = (keylen_q == AES_256_BIT_KEY) ? AES256_ROUNDS : AES128_ROUNDS;

    // Next round key and S-box request for the key being written this cycle.
    always_comb begin
        sboxw_s    = 32'h0;
        t_s        = 32'h0;
        new_key_d  = 128'h0;
        rcon_adv_s = 1'b0;
        if (state_q == ST_GEN) begin
            if (round_ctr_q == 4'd0) begin
                new_key_d = key[255:128];
            end else if ((round_ctr_q == 4'd1) && (keylen_q == AES_256_BIT_KEY)) begin
                new_key_d = key[127:0];
            end else if (keylen_q == AES_128_BIT_KEY) begin
                sboxw_s    = rot_word(prev_key1_q[31:0]);
                t_s        = new_sboxw ^ {rcon_q, 24'h0};
                new_key_d  = xor_chain(prev_key1_q, t_s);
                rcon_adv_s = 1'b1;
            end else if (round_ctr_q[0] == 1'b0) begin
                // AES-256 even round: rotated, rcon-mixed word, chained over key r-2.
                sboxw_s    = rot_word(prev_key1_q[31:0]);
                t_s        = new_sboxw ^ {rcon_q, 24'h0};
                new_key_d  = xor_chain(prev_key0_q, t_s);
                rcon_adv_s = 1'b1;
            end else begin
                // AES-256 odd round: plain SubWord, no rotation or rcon.
                sboxw_s    = prev_key1_q[31:0];
                t_s        = new_sboxw;
                new_key_d  = xor_chain(prev_key0_q, t_s);
                rcon_adv_s = 1'b0;
            end
        end else begin
            sboxw_s    = 32'h0;
            new_key_d  = 128'h0;
            rcon_adv_s = 1'b0;
        end
    end

    // Expansion sequencer: idle/generate/done with key history and rcon.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            round_ctr_q <= 4'd0;
            rcon_q      <= 8'h01;
            keylen_q    <= 1'b0;
            ready_q     <= 1'b1;
            prev_key0_q <= 128'h0;
            prev_key1_q <= 128'h0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (init) begin
                        keylen_q    <= keylen;
                        round_ctr_q <= 4'd0;
                        rcon_q      <= 8'h01;
                        ready_q     <= 1'b0;
                        state_q     <= ST_GEN;
                    end else begin
                        state_q     <= ST_IDLE;
                    end
                end
                ST_GEN: begin
                    prev_key0_q <= prev_key1_q;
                    prev_key1_q <= new_key_d;
                    if (rcon_adv_s) begin
                        rcon_q <= rcon_next(rcon_q);
                    end else begin
                        rcon_q <= rcon_q;
                    end
                    if (round_ctr_q == last_round_s) begin
                        state_q <= ST_DONE;
                    end else begin
                        round_ctr_q <= round_ctr_q + 4'd1;
                    end
                end
                ST_DONE: begin
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Round key storage; one entry written per generate cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 15; i++) begin
                key_mem_q[i] <= 128'h0;
            end
        end else begin
            if (state_q == ST_GEN) begin
                key_mem_q[round_ctr_q] <= new_key_d;
            end
        end
    end

    assign round_key = (round == 4'hf) ? 128'h0 : key_mem_q[round];
    assign ready     = ready_q;
    assign sboxw     = sboxw_s;

endmodule

// File: tb/tb_aes_key_mem.sv
// -----------------------------------------------------------------------------
// tb_aes_key_mem
// Self-checking bench for aes_key_mem. Provides the shared S-box from a table
// derived from GF(2^8) inversion plus the affine map, and compares round keys
// against a word-oriented key schedule model (w[i] = w[i-Nk] ^ temp).
// -----------------------------------------------------------------------------
module tb_aes_key_mem;

    logic         clk;
    logic         reset_n;
    logic [255:0] key;
    logic         keylen;
    logic         init;
    logic [3:0]   round;
    logic [127:0] round_key;
    logic         ready;
    logic [31:0]  sboxw;
    logic [31:0]  new_sboxw;

    logic [7:0]   sbox_tab [256];
    logic [127:0] mdl_mem  [15];
    logic [127:0] mdl_new  [15];

    int errors;
    int checks;

    aes_key_mem dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .key       (key),
        .keylen    (keylen),
        .init      (init),
        .round     (round),
        .round_key (round_key),
        .ready     (ready),
        .sboxw     (sboxw),
        .new_sboxw (new_sboxw)
    );

    assign new_sboxw = {sbox_tab[sboxw[31:24]], sbox_tab[sboxw[23:16]],
                        sbox_tab[sboxw[15:8]],  sbox_tab[sboxw[7:0]]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = xt(aa);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [31:0] sub_w(input logic [31:0] w);
        return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++) begin
                if (gmul(8'(x), 8'(b)) == 8'h01) inv = 8'(b);
            end
            sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // Standard word-based key schedule; entries beyond the last round stay stale.
    task automatic model_expand(input logic [255:0] k, input logic kl);
        logic [31:0] w [60];
        logic [31:0] tmp;
        logic [7:0]  rc;
        int nk, nr;
        nk = kl ? 8 : 4;
        nr = kl ? 14 : 10;
        for (int i = 0; i < nk; i++) w[i] = k[255 - 32*i -: 32];
        rc = 8'h01;
        for (int i = nk; i < 4*(nr+1); i++) begin
            tmp = w[i-1];
            if (i % nk == 0) begin
                tmp = sub_w({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (nk == 8 && i % 8 == 4) begin
                tmp = sub_w(tmp);
            end
            w[i] = w[i-nk] ^ tmp;
        end
        for (int r = 0; r < 15; r++) begin
            mdl_new[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : mdl_mem[r];
        end
    endtask

    task automatic read_check(input string tag, input int r, input logic [127:0] exp);
        round = 4'(r);
        #1;
        check_val(tag, round_key, exp);
    endtask

    task automatic sweep_check(input string tag);
        for (int r = 0; r < 16; r++) begin
            read_check(tag, r, (r == 15) ? 128'h0 : mdl_mem[r]);
        end
        @(negedge clk);
    endtask

    // ghost: 0 none, 1 = init + keylen flip mid-expansion, 2 = init in DONE cycle
    task automatic run_expand(input logic [255:0] k, input logic kl, input int ghost);
        int n;
        int lat;
        lat = kl ? 16 : 12;
        key    = k;
        keylen = kl;
        init   = 1'b1;
        @(negedge clk);
        init = 1'b0;
        model_expand(k, kl);
        n = 0;
        while (ready == 1'b0 && n < 40) begin
            if (n == 2) begin
                round = 4'd10;
                #1;
                check_val("mid_read_old", round_key, mdl_mem[10]);
            end
            if ((ghost == 1 && n == 3) || (ghost == 2 && n == lat - 1)) begin
                init   = 1'b1;
                keylen = ~kl;
            end else begin
                init   = 1'b0;
                keylen = kl;
            end
            @(negedge clk);
            n++;
        end
        init   = 1'b0;
        keylen = kl;
        check_val("latency", 128'(n), 128'(lat));
        check_val("sboxw_idle", 128'(sboxw), 128'h0);
        @(negedge clk);
        check_val("ready_stays", 128'(ready), 128'h1);
        for (int r = 0; r < 15; r++) mdl_mem[r] = mdl_new[r];
        sweep_check("key_sweep");
    endtask

    localparam logic [255:0] K_FIPS  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K_SEQ   = {128'h000102030405060708090a0b0c0d0e0f, 128'hffeeddccbbaa99887766554433221100};
    localparam logic [255:0] K_256   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    initial begin
        logic [255:0] rk;
        logic         rkl;
        errors  = 0;
        checks  = 0;
        reset_n = 1'b0;
        init    = 1'b0;
        key     = 256'h0;
        keylen  = 1'b0;
        round   = 4'd0;
        for (int r = 0; r < 15; r++) mdl_mem[r] = 128'h0;
        build_sbox();
        check_val("sbox_00", 128'(sbox_tab[0]), 128'h63);
        check_val("sbox_53", 128'(sbox_tab[8'h53]), 128'hed);
        repeat (2) @(negedge clk);
        check_val("rst_ready", 128'(ready), 128'h1);
        check_val("rst_sboxw", 128'(sboxw), 128'h0);
        reset_n = 1'b1;
        @(negedge clk);
        sweep_check("rst_key");

        run_expand(K_FIPS, 1'b0, 0);
        read_check("fips128_r1",  1,  128'ha0fafe1788542cb123a339392a6c7605);
        read_check("fips128_r10", 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        @(negedge clk);

        run_expand(K_SEQ, 1'b0, 1);
        read_check("seq128_r0",  0,  128'h000102030405060708090a0b0c0d0e0f);
        read_check("seq128_r10", 10, 128'h13111d7fe3944a17f307a78b4d2b30c5);
        @(negedge clk);

        run_expand(K_256, 1'b1, 2);
        read_check("aes256_r1",  1,  128'h101112131415161718191a1b1c1d1e1f);
        read_check("aes256_r14", 14, 128'h24fc79ccbf0979e9371ac23c6d68de36);
        @(negedge clk);

        // AES-128 after AES-256: stale upper entries are covered by the sweep.
        run_expand(K_FIPS, 1'b0, 0);

        // Reset in the middle of an AES-256 expansion.
        key    = K_256;
        keylen = 1'b1;
        init   = 1'b1;
        @(negedge clk);
        init = 1'b0;
        repeat (5) @(negedge clk);
        check_val("mid_busy", 128'(ready), 128'h0);
        reset_n = 1'b0;
        #1;
        check_val("async_ready", 128'(ready), 128'h1);
        check_val("async_sboxw", 128'(sboxw), 128'h0);
        for (int r = 0; r < 15; r++) mdl_mem[r] = 128'h0;
        for (int r = 0; r < 16; r++) read_check("async_zero", r, 128'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run_expand(K_256, 1'b1, 0);

        for (int it = 0; it < 8; it++) begin
            for (int j = 0; j < 8; j++) rk[32*j +: 32] = $urandom;
            rkl = 1'($urandom_range(0, 1));
            run_expand(rk, rkl, int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
